// File: rtl/enc_8b10b_stream.sv
// enc_8b10b_stream
//   Multi-symbol 8b/10b stream encoder with a valid/ready handshake and a running
//   disparity (RD) that chains symbol-to-symbol and word-to-word. One registered
//   output stage; full throughput (one word per cycle).
//
// Parameters
//   NSYM     symbols per word (>= 1); symbol 0 in the LSBs, transmitted first
//   RD_INIT  RD after reset (0: RD-, 1: RD+)
//
// Ports
//   clk_i       clock
//   reset_i     synchronous active-high reset
//   data_i      NSYM x {K, HGFEDCBA}; symbol i at [9i+8:9i]
//   valid_i     input word valid
//   ready_o     input word accepted when valid_i & ready_o
//   rdSet_i     force RD (resync), single-cycle pulse
//   rdSetVal_i  RD value applied with rdSet_i
//   data_o      NSYM x abcdeifghj; symbol i at [10i+9:10i], 'a' at MSB
//   valid_o     output word valid
//   ready_i     sink accepts when valid_o & ready_i
//   rd_o        RD register (RD used by the next accepted word)
//   kErr_o      invalid K code flag, present only when ENC8B10B_KCHECK_EN is defined
//
// Configuration
//   ENC8B10B_KCHECK_EN  when defined, adds kErr_o and the K-code validity check.

module enc_8b10b_stream #(
  parameter int unsigned NSYM    = 2,
  parameter logic        RD_INIT = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NSYM*9-1:0]  data_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               rdSet_i,
  input  logic               rdSetVal_i,
  output logic [NSYM*10-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               rd_o
`ifdef ENC8B10B_KCHECK_EN
  ,
  output logic               kErr_o
`endif
);

  // 5b/6b code for RD- (abcdei, 'a' at MSB).
  function automatic logic [5:0] code6_neg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:    c = 6'b100111;
      5'd1:    c = 6'b011101;
      5'd2:    c = 6'b101101;
      5'd3:    c = 6'b110001;
      5'd4:    c = 6'b110101;
      5'd5:    c = 6'b101001;
      5'd6:    c = 6'b011001;
      5'd7:    c = 6'b111000;
      5'd8:    c = 6'b111001;
      5'd9:    c = 6'b100101;
      5'd10:   c = 6'b010101;
      5'd11:   c = 6'b110100;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b101100;
      5'd14:   c = 6'b011100;
      5'd15:   c = 6'b010111;
      5'd16:   c = 6'b011011;
      5'd17:   c = 6'b100011;
      5'd18:   c = 6'b010011;
      5'd19:   c = 6'b110010;
      5'd20:   c = 6'b001011;
      5'd21:   c = 6'b101010;
      5'd22:   c = 6'b011010;
      5'd23:   c = 6'b111010;
      5'd24:   c = 6'b110011;
      5'd25:   c = 6'b100110;
      5'd26:   c = 6'b010110;
      5'd27:   c = 6'b110110;
      5'd28:   c = 6'b001110;
      5'd29:   c = 6'b101110;
      5'd30:   c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b data code when entering the 4b block at RD- (fghj, 'f' at MSB).
  function automatic logic [3:0] code4d_neg(input logic [2:0] y, input logic alt7);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = alt7 ? 4'b0111 : 4'b1110;
    endcase
    return c;
  endfunction

  // 3b/4b control code when entering the 4b block at RD-; RD+ is always the complement.
  function automatic logic [3:0] code4k_neg(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b0110;
      3'd2:    c = 4'b1010;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b0101;
      3'd6:    c = 4'b1001;
      default: c = 4'b0111;
    endcase
    return c;
  endfunction

  // Returns {rd_out, abcdei, fghj} for one symbol {K, HGFEDCBA}.
  function automatic logic [10:0] enc_sym(input logic [8:0] s, input logic rd_in);
    logic       k;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       unbal6, unbal4, rd_mid, alt7, comp4;
    k = s[8];
    x = s[4:0];
    y = s[7:5];
    c6 = (k && x == 5'd28) ? 6'b001111 : code6_neg(x);
    unbal6 = ($countones(c6) != 3);
    // D.7 is balanced but still alternates (111000 / 000111).
    if (rd_in && (unbal6 || x == 5'd7)) c6 = ~c6;
    rd_mid = rd_in ^ unbal6;
    // A7 avoids a run of five identical bits across the 6b/4b boundary.
    alt7 = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
           ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    c4 = k ? code4k_neg(y) : code4d_neg(y, alt7);
    unbal4 = ($countones(c4) != 2);
    comp4 = rd_mid && (k || unbal4 || y == 3'd3);
    if (comp4) c4 = ~c4;
    return {rd_mid ^ unbal4, c6, c4};
  endfunction

  logic [NSYM*10-1:0] data_q, data_d, enc_word;
  logic               valid_q, valid_d;
  logic               rd_q, rd_d, rd_end;
  logic               accept;

`ifdef ENC8B10B_KCHECK_EN
  logic kerr_q, kerr_d, kerr_word;
`endif

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;

  // RD chain through all symbols of the word.
  always_comb begin
    logic        rd_run;
    logic [10:0] res;
    rd_run   = rdSet_i ? rdSetVal_i : rd_q;
    enc_word = '0;
    res      = '0;
`ifdef ENC8B10B_KCHECK_EN
    kerr_word = 1'b0;
`endif
    for (int unsigned i = 0; i < NSYM; i++) begin
      res = enc_sym(data_i[9*i +: 9], rd_run);
      enc_word[10*i +: 10] = res[9:0];
      rd_run = res[10];
`ifdef ENC8B10B_KCHECK_EN
      // Valid K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
      if (data_i[9*i+8] &&
          !(data_i[9*i +: 5] == 5'd28 ||
            (data_i[9*i+5 +: 3] == 3'd7 &&
             (data_i[9*i +: 5] == 5'd23 || data_i[9*i +: 5] == 5'd27 ||
              data_i[9*i +: 5] == 5'd29 || data_i[9*i +: 5] == 5'd30)))) begin
        kerr_word = 1'b1;
      end
`endif
    end
    rd_end = rd_run;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    rd_d    = rd_q;
`ifdef ENC8B10B_KCHECK_EN
    kerr_d  = kerr_q;
`endif
    if (accept) begin
      data_d  = enc_word;
      valid_d = 1'b1;
      rd_d    = rd_end;
`ifdef ENC8B10B_KCHECK_EN
      kerr_d  = kerr_word;
`endif
    end else begin
      if (ready_i) valid_d = 1'b0;
      // Under backpressure the held word is not re-encoded; only the RD register moves.
      if (rdSet_i) rd_d = rdSetVal_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      rd_q    <= RD_INIT;
`ifdef ENC8B10B_KCHECK_EN
      kerr_q  <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
`ifdef ENC8B10B_KCHECK_EN
      kerr_q  <= kerr_d;
`endif
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign rd_o    = rd_q;
`ifdef ENC8B10B_KCHECK_EN
  assign kErr_o  = kerr_q;
`endif

endmodule
